// File: rtl/seq_divider_hs.sv
// -----------------------------------------------------------------------------
// seq_divider_hs
// Multi-cycle restoring integer divider with a start/done handshake.
// Operands are captured when start is accepted in IDLE. The quotient and
// remainder are produced STEPS_PER_CYCLE bits per clock. Results are registered
// and held until the next completion. A zero divisor is detected at accept and
// answered after one cycle.
//
// Optional feature macro: SIGNED_DIV_EN
//   When defined, is_signed=1 selects two's-complement truncating division.
//   When not defined, is_signed is ignored and only unsigned logic is built.
//
// Parameters:
//   WIDTH_A          dividend / quotient width
//   WIDTH_B          divisor / remainder width (WIDTH_B <= WIDTH_A)
//   STEPS_PER_CYCLE  restoring iterations per clock (must divide WIDTH_A)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   divide request, sampled only while busy=0
//   A            in   dividend, captured at accept
//   B            in   divisor, captured at accept
//   is_signed    in   two's-complement select (SIGNED_DIV_EN builds only)
//   busy         out  operation in progress
//   done         out  one-cycle pulse when Q, R and div_by_zero update
//   Q            out  quotient, held until the next completion
//   R            out  remainder, held until the next completion
//   div_by_zero  out  set with done when the captured divisor was zero
// -----------------------------------------------------------------------------
module seq_divider_hs #(
  parameter int WIDTH_A         = 8,
  parameter int WIDTH_B         = 8,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  input  logic               is_signed,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_A-1:0] Q,
  output logic [WIDTH_B-1:0] R,
  output logic               div_by_zero
);

  localparam int N     = WIDTH_A / STEPS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if ((WIDTH_A % STEPS_PER_CYCLE) != 0) begin : g_bad_steps
    $error("seq_divider_hs: STEPS_PER_CYCLE must divide WIDTH_A exactly");
  end
  if (WIDTH_B > WIDTH_A) begin : g_bad_width
    $error("seq_divider_hs: WIDTH_B must not exceed WIDTH_A");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ZERO = 2'd2
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH_B:0]   rem_r;    // one extra bit so the compare never overflows
  logic [WIDTH_A-1:0] quo_r;    // dividend shifts out of the top, quotient in at the bottom
  logic [WIDTH_B-1:0] dvs_r;
  logic [WIDTH_B-1:0] a_low_r;  // raw A low bits, returned as R on divide by zero
  logic               neg_q_r;
  logic               neg_r_r;

  logic               sgn_s;
  logic [WIDTH_A-1:0] a_mag_s;
  logic [WIDTH_B-1:0] b_mag_s;
  logic               b_zero_s;
  logic [WIDTH_B:0]   rem_n_s;
  logic [WIDTH_A-1:0] quo_n_s;
  logic [WIDTH_A-1:0] q_fin_s;
  logic [WIDTH_B-1:0] r_fin_s;

  // Two's-complement negation helpers
  function automatic logic [WIDTH_A-1:0] neg_a(input logic [WIDTH_A-1:0] v);
    neg_a = ~v + WIDTH_A'(1);
  endfunction

  function automatic logic [WIDTH_B-1:0] neg_b(input logic [WIDTH_B-1:0] v);
    neg_b = ~v + WIDTH_B'(1);
  endfunction

`ifdef SIGNED_DIV_EN
  assign sgn_s = is_signed;
`else
  logic unused_is_signed_s;
  assign sgn_s = 1'b0;
  assign unused_is_signed_s = is_signed;
`endif

  // Operand magnitudes and sign flags presented at accept
  always_comb begin
    a_mag_s  = A;
    b_mag_s  = B;
    b_zero_s = (B == {WIDTH_B{1'b0}});
    if (sgn_s && A[WIDTH_A-1]) begin
      a_mag_s = neg_a(A);
    end else begin
      a_mag_s = A;
    end
    if (sgn_s && B[WIDTH_B-1]) begin
      b_mag_s = neg_b(B);
    end else begin
      b_mag_s = B;
    end
  end

  // STEPS_PER_CYCLE restoring shift/compare/subtract steps
  always_comb begin
    rem_n_s = rem_r;
    quo_n_s = quo_r;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      rem_n_s = {rem_n_s[WIDTH_B-1:0], quo_n_s[WIDTH_A-1]};
      quo_n_s = quo_n_s << 1'b1;
      if (rem_n_s >= {1'b0, dvs_r}) begin
        rem_n_s    = rem_n_s - {1'b0, dvs_r};
        quo_n_s[0] = 1'b1;
      end else begin
        quo_n_s[0] = 1'b0;
      end
    end
  end

  // Sign correction at the final load (quotient and remainder magnitudes)
  always_comb begin
    q_fin_s = quo_n_s;
    r_fin_s = rem_n_s[WIDTH_B-1:0];
    if (neg_q_r) begin
      q_fin_s = neg_a(quo_n_s);
    end else begin
      q_fin_s = quo_n_s;
    end
    if (neg_r_r) begin
      r_fin_s = neg_b(rem_n_s[WIDTH_B-1:0]);
    end else begin
      r_fin_s = rem_n_s[WIDTH_B-1:0];
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      rem_r       <= {(WIDTH_B+1){1'b0}};
      quo_r       <= {WIDTH_A{1'b0}};
      dvs_r       <= {WIDTH_B{1'b0}};
      a_low_r     <= {WIDTH_B{1'b0}};
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      Q           <= {WIDTH_A{1'b0}};
      R           <= {WIDTH_B{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            quo_r   <= a_mag_s;
            dvs_r   <= b_mag_s;
            a_low_r <= A[WIDTH_B-1:0];
            rem_r   <= {(WIDTH_B+1){1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            neg_q_r <= sgn_s & (A[WIDTH_A-1] ^ B[WIDTH_B-1]);
            neg_r_r <= sgn_s & A[WIDTH_A-1];
            busy    <= 1'b1;
            state_r <= b_zero_s ? S_ZERO : S_CALC;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          rem_r <= rem_n_s;
          quo_r <= quo_n_s;
          if (cnt_r == CNT_LAST) begin
            Q           <= q_fin_s;
            R           <= r_fin_s;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            state_r     <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_ZERO: begin
          Q           <= {WIDTH_A{1'b1}};
          R           <= a_low_r;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_r     <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_hs.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_hs
// Directed bench for seq_divider_hs with two instances:
//   u_dut1: WIDTH_A=8, WIDTH_B=4, STEPS_PER_CYCLE=1 (N=8)
//   u_dut2: WIDTH_A=8, WIDTH_B=8, STEPS_PER_CYCLE=2 (N=4)
// The signed vectors' expected results depend on whether SIGNED_DIV_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_divider_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start1, start2, sgn, sel;
  logic [7:0] a, b;

  logic       busy1, done1, dbz1;
  logic [7:0] q1;
  logic [3:0] r1;
  logic       busy2, done2, dbz2;
  logic [7:0] q2, r2;

  logic       busy_m, done_m, dbz_m;
  logic [7:0] q_m, r_m;

  seq_divider_hs #(.WIDTH_A(8), .WIDTH_B(4), .STEPS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .A(a), .B(b[3:0]),
    .is_signed(sgn), .busy(busy1), .done(done1), .Q(q1), .R(r1),
    .div_by_zero(dbz1)
  );

  seq_divider_hs #(.WIDTH_A(8), .WIDTH_B(8), .STEPS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .A(a), .B(b),
    .is_signed(sgn), .busy(busy2), .done(done2), .Q(q2), .R(r2),
    .div_by_zero(dbz2)
  );

  // Route the selected instance's outputs to common check signals
  always_comb begin
    busy_m = sel ? busy2 : busy1;
    done_m = sel ? done2 : done1;
    dbz_m  = sel ? dbz2  : dbz1;
    q_m    = sel ? q2    : q1;
    r_m    = sel ? r2    : {4'h0, r1};
  end

  typedef struct {
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       sg;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vt [NVEC];

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one request to the selected instance; returns #1 after the accept edge
  task automatic start_op(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic sg);
    @(negedge clk);
    sel = s; a = av; b = bv; sgn = sg;
    if (s) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Count cycles from the accept edge until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 40 && !done_m) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input int idx);
    int lat;
    string tag;
    start_op(vt[idx].sel, vt[idx].a, vt[idx].b, vt[idx].sg);
    wait_done(lat);
    tag = $sformatf("v%0d", idx);
    check({tag, "_lat"}, lat, vt[idx].lat);
    check({tag, "_q"}, q_m, vt[idx].q);
    check({tag, "_r"}, r_m, vt[idx].r);
    check({tag, "_dbz"}, dbz_m, vt[idx].dbz);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, done_m, 1'b0);
    n_vec++;
  endtask

  initial begin
    int  lat;
    logic seen;

    // sel a b sg  q r dbz lat
    vt[0]  = '{1'b0, 8'd100, 8'd7,  1'b0, 8'd14,  8'd2,  1'b0, 8};
    vt[1]  = '{1'b0, 8'h5A,  8'd0,  1'b0, 8'hFF,  8'h0A, 1'b1, 1};
    vt[2]  = '{1'b0, 8'd9,   8'd3,  1'b0, 8'd3,   8'd0,  1'b0, 8};
    vt[3]  = '{1'b0, 8'd200, 8'd9,  1'b0, 8'd22,  8'd2,  1'b0, 8};
    vt[4]  = '{1'b0, 8'd255, 8'd15, 1'b0, 8'd17,  8'd0,  1'b0, 8};
    vt[5]  = '{1'b0, 8'd7,   8'd9,  1'b0, 8'd0,   8'd7,  1'b0, 8};
    vt[6]  = '{1'b0, 8'd255, 8'd1,  1'b0, 8'd255, 8'd0,  1'b0, 8};
    vt[7]  = '{1'b1, 8'd254, 8'd3,  1'b0, 8'd84,  8'd2,  1'b0, 4};
    vt[8]  = '{1'b1, 8'd200, 8'd200,1'b0, 8'd1,   8'd0,  1'b0, 4};
    vt[9]  = '{1'b1, 8'h37,  8'd0,  1'b0, 8'hFF,  8'h37, 1'b1, 1};
    vt[10] = '{1'b1, 8'h80,  8'hFF, 1'b0, 8'h00,  8'h80, 1'b0, 4};
`ifdef SIGNED_DIV_EN
    vt[11] = '{1'b0, 8'hF9,  8'h02, 1'b1, 8'hFD,  8'h0F, 1'b0, 8};
    vt[12] = '{1'b0, 8'h07,  8'h0E, 1'b1, 8'hFD,  8'h01, 1'b0, 8};
    vt[13] = '{1'b1, 8'h80,  8'hFF, 1'b1, 8'h80,  8'h00, 1'b0, 4};
    vt[15] = '{1'b1, 8'h9C,  8'h07, 1'b1, 8'hF2,  8'hFE, 1'b0, 4};
`else
    vt[11] = '{1'b0, 8'hF9,  8'h02, 1'b1, 8'h7C,  8'h01, 1'b0, 8};
    vt[12] = '{1'b0, 8'h07,  8'h0E, 1'b1, 8'h00,  8'h07, 1'b0, 8};
    vt[13] = '{1'b1, 8'h80,  8'hFF, 1'b1, 8'h00,  8'h80, 1'b0, 4};
    vt[15] = '{1'b1, 8'h9C,  8'h07, 1'b1, 8'h16,  8'h02, 1'b0, 4};
`endif
    vt[14] = '{1'b0, 8'h80,  8'h00, 1'b1, 8'hFF,  8'h00, 1'b1, 1};

    reset = 1'b1; start1 = 1'b0; start2 = 1'b0; sgn = 1'b0; sel = 1'b0;
    a = 8'd0; b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy1", busy1, 1'b0);
    check("rst_done1", done1, 1'b0);
    check("rst_q1", q1, 8'd0);
    check("rst_r1", r1, 4'd0);
    check("rst_dbz1", dbz1, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    check("rst_q2", q2, 8'd0);
    reset = 1'b0;

    // 100/7 then results must hold while idle
    run_vec(0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", q1, 8'd14);
    check("hold_r", r1, 4'd2);
    check("hold_done", done1, 1'b0);
    check("hold_busy", busy1, 1'b0);

    // Reset during the 3rd CALC cycle of 200/9 discards the operation
    start_op(1'b0, 8'd200, 8'd9, 1'b0);
    check("calc_busy", busy1, 1'b1);
    @(posedge clk);
    #1;
    check("calc_q_kept", q1, 8'd14);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_busy", busy1, 1'b0);
    check("midrst_done", done1, 1'b0);
    check("midrst_q", q1, 8'd0);
    check("midrst_r", r1, 4'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen = seen | done1;
    end
    check("midrst_no_done", seen, 1'b0);

    // STEPS=2: start held while busy is ignored, start in the done cycle is accepted
    start_op(1'b1, 8'd255, 8'd16, 1'b0);
    @(negedge clk);
    a = 8'd1; b = 8'd1; start2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_busy", busy2, 1'b1);
    check("b2b_early_done", done2, 1'b0);
    @(negedge clk);
    a = 8'd200; b = 8'd9;
    @(posedge clk);
    #1;
    check("b2b_done", done2, 1'b1);
    check("b2b_q1", q2, 8'd15);
    check("b2b_r1", r2, 8'd15);
    @(posedge clk);
    #1;
    start2 = 1'b0;
    check("b2b_accepted", busy2, 1'b1);
    check("b2b_pulse", done2, 1'b0);
    wait_done(lat);
    check("b2b_lat", lat, 4);
    check("b2b_q2", q2, 8'd22);
    check("b2b_r2", r2, 8'd2);
    n_vec++;

    // Table-driven vectors
    for (int i = 1; i < NVEC; i++) begin
      run_vec(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
